drm_metering_arbiter: RTL

DRM_METERING_ARBITER -- requirements
Module: drm_metering_arbiter

---
 rtl/drm_metering_pkg.sv | 13 +
 rtl/drm_rr_select.sv | 36 +++
 rtl/drm_metering_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/drm_metering_pkg.sv
// Shared types and limits for the DRM metering arbiter.
// Optional feature macro: DRM_METERING_OVERFLOW_STATUS_EN (see drm_metering_arbiter).
package drm_metering_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_MAX = 16;
    localparam int CNT_W_MAX   = 16;

endpackage

// File: rtl/drm_rr_select.sv
// Combinational round-robin pick: first set request strictly after last,
// wrapping to index 0; last itself has lowest priority.
module drm_rr_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       grant_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        // Walk from farthest to nearest so the nearest candidate wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, last} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drm_metering_arbiter.sv
// Per-requester pending-event counters arbitrated onto one activator metering port.
// Define DRM_METERING_OVERFLOW_STATUS_EN to add sticky saturation flags (overflow/overflow_clr).
module drm_metering_arbiter
    import drm_metering_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                       ip_core_aclk,
    input  logic                       ip_core_reset,
    input  logic                       activation_code_enable,
    input  logic [NUM_REQ-1:0]         req_event,
    output logic                       evt_valid,
    output logic [$clog2(NUM_REQ)-1:0] evt_src,
    input  logic                       evt_ready,
    output logic                       pending_any
`ifdef DRM_METERING_OVERFLOW_STATUS_EN
    ,
    output logic [NUM_REQ-1:0]         overflow,
    input  logic [NUM_REQ-1:0]         overflow_clr
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] nz_q, nz_d, inc, dec;
    logic [IDX_W-1:0]   last_q, last_d, src_d, gnt;
    logic               gnt_valid, valid_d, hs;

    assign hs = evt_valid & evt_ready;

    drm_rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_sel (
        .req        (nz_q),
        .last       (last_q),
        .grant      (gnt),
        .grant_valid(gnt_valid)
    );

    // A saturated counter still takes a pulse when it is also being drained.
    always_comb begin
        inc  = '0;
        dec  = '0;
        nz_q = '0;
        nz_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            nz_q[i]  = |cnt_q[i];
            dec[i]   = hs && (evt_src == IDX_W'(i));
            inc[i]   = req_event[i] && activation_code_enable
                       && ((cnt_q[i] != CNT_MAX) || dec[i]);
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            nz_d[i] = |cnt_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = evt_valid;
        src_d   = evt_src;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (activation_code_enable && gnt_valid) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    src_d   = gnt;
                end
            end
            SEND: begin
                // Offer stays up even if the activator locks meanwhile.
                if (evt_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = evt_src;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ip_core_aclk) begin
        if (ip_core_reset) begin
            state_q     <= IDLE;
            evt_valid   <= 1'b0;
            evt_src     <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            pending_any <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            evt_valid   <= valid_d;
            evt_src     <= src_d;
            last_q      <= last_d;
            pending_any <= |nz_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef DRM_METERING_OVERFLOW_STATUS_EN
    logic [NUM_REQ-1:0] drop;

    always_comb begin
        drop = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drop[i] = req_event[i] && activation_code_enable && !inc[i];
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge ip_core_aclk) begin
        if (ip_core_reset) begin
            overflow <= '0;
        end else begin
            overflow <= (overflow & ~overflow_clr) | drop;
        end
    end
`endif

endmodule
